// File: rtl/data_memory_sized.sv
// Byte-addressable 64-bit data memory with B/H/W/D access sizes, registered read port and range checking.
// Boundary-crossing accesses take two cycles (Stall raised in the first); aligned accesses take one.
module data_memory_sized #(
    parameter int unsigned DEPTH_BYTES = 1024,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter bit          MISALIGN_EN = 1'b1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [63:0]           Data_write,
    input  logic                  MemWrite,
    input  logic                  MemRead,
    input  logic [2:0]            funct3,
    output logic                  Stall,
    output logic [63:0]           Data_read,
    output logic                  Read_valid,
    output logic                  Addr_err
);
    localparam int unsigned IW = $clog2(DEPTH_BYTES);

    typedef enum logic {S_IDLE, S_SPLIT} state_t;

    state_t      state_q, state_d;
    logic [63:0] low_q, low_d;
    logic [63:0] data_read_q, data_read_d;
    logic        read_valid_q, read_valid_d;
    logic        addr_err_q, addr_err_d;

    logic [7:0] mem [DEPTH_BYTES] = '{default: 8'h00};

    logic [3:0]    size, low_len, part_len;
    logic [2:0]    offset, part_src;
    logic [IW-1:0] addr_idx, part_base;
    logic [IW:0]   last_idx;
    logic          req, is_rd, crossing, err, wr_en, sx;
    logic [IW-1:0] byte_idx [8];
    logic [2:0]    byte_pos [8];
    logic [7:0]    byte_wdat [8];
    logic [7:0]    byte_we;
    logic [7:0]    asm_b [8];
    logic [63:0]   raw, ext;

    // Address decode and the byte window touched by the current part.
    always_comb begin
        size     = 4'd1 << funct3[1:0];
        offset   = address[2:0];
        addr_idx = address[IW-1:0];
        req      = MemRead | MemWrite;
        is_rd    = MemRead & ~MemWrite;
        sx       = ~funct3[2];
        crossing = ({1'b0, offset} + size) > 4'd8;
        last_idx = {1'b0, addr_idx} + (IW+1)'(size) - (IW+1)'(1);
        err      = last_idx[IW] | (address[ADDR_WIDTH-1:IW] != '0) |
                   (funct3 == 3'b111) | (crossing & ~MISALIGN_EN);
        low_len  = 4'd8 - {1'b0, offset};

        part_base = addr_idx;
        part_len  = size;
        part_src  = 3'd0;
        if (state_q == S_SPLIT) begin
            part_base = addr_idx + IW'(low_len);
            part_len  = size - low_len;
            part_src  = low_len[2:0];
        end else if (crossing) begin
            part_len  = low_len;
        end

        wr_en = Reset_n & MemWrite & ((state_q == S_SPLIT) | ~err);

        for (int k = 0; k < 8; k++) begin
            asm_b[k] = (state_q == S_SPLIT) ? low_q[8*k +: 8] : 8'h00;
        end
        for (int i = 0; i < 8; i++) begin
            byte_idx[i]  = part_base + IW'(i);
            byte_pos[i]  = part_src + 3'(i);
            byte_we[i]   = wr_en & (4'(i) < part_len);
            byte_wdat[i] = Data_write[8*byte_pos[i] +: 8];
            if (4'(i) < part_len) begin
                asm_b[byte_pos[i]] = mem[byte_idx[i]];
            end
        end
        raw = {asm_b[7], asm_b[6], asm_b[5], asm_b[4],
               asm_b[3], asm_b[2], asm_b[1], asm_b[0]};

        case (funct3[1:0])
            2'd0:    ext = {{56{sx & raw[7]}},  raw[7:0]};
            2'd1:    ext = {{48{sx & raw[15]}}, raw[15:0]};
            2'd2:    ext = {{32{sx & raw[31]}}, raw[31:0]};
            default: ext = raw;
        endcase
    end

    // Control: in SPLIT the held inputs are trusted, so err is not re-evaluated.
    always_comb begin
        state_d      = state_q;
        low_d        = low_q;
        data_read_d  = data_read_q;
        read_valid_d = 1'b0;
        addr_err_d   = 1'b0;
        Stall        = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    if (err) begin
                        addr_err_d   = 1'b1;
                        data_read_d  = 64'h0;
                        read_valid_d = is_rd;
                    end else if (crossing) begin
                        Stall   = Reset_n;
                        low_d   = raw;
                        state_d = S_SPLIT;
                    end else if (is_rd) begin
                        data_read_d  = ext;
                        read_valid_d = 1'b1;
                    end
                end
            end
            S_SPLIT: begin
                state_d = S_IDLE;
                if (is_rd) begin
                    data_read_d  = ext;
                    read_valid_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q      <= S_IDLE;
            low_q        <= 64'h0;
            data_read_q  <= 64'h0;
            read_valid_q <= 1'b0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            low_q        <= low_d;
            data_read_q  <= data_read_d;
            read_valid_q <= read_valid_d;
            addr_err_q   <= addr_err_d;
        end
    end

    // Storage is not cleared by reset; writes are already gated by Reset_n.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < 8; i++) begin
            if (byte_we[i]) begin
                mem[byte_idx[i]] <= byte_wdat[i];
            end
        end
    end

    assign Data_read  = data_read_q;
    assign Read_valid = read_valid_q;
    assign Addr_err   = addr_err_q;
endmodule

// File: tb/tb_data_memory_sized.sv
// Directed bench for data_memory_sized: table of single-cycle accesses plus split/reset/no-misalign sequences.
module tb_data_memory_sized;
    localparam logic [2:0] F_B = 3'd0, F_H = 3'd1, F_W = 3'd2, F_D = 3'd3;
    localparam logic [2:0] F_BU = 3'd4, F_HU = 3'd5, F_WU = 3'd6, F_BAD = 3'd7;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [63:0] address, Data_write;
    logic        MemWrite, MemRead;
    logic [2:0]  funct3;
    logic        Stall, Read_valid, Addr_err;
    logic [63:0] Data_read;
    logic        Stall0, Read_valid0, Addr_err0;
    logic [63:0] Data_read0;

    int checks = 0;
    int errors = 0;

    always #5 Clk = ~Clk;

    data_memory_sized #(.DEPTH_BYTES(1024), .ADDR_WIDTH(64), .MISALIGN_EN(1'b1)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .address(address), .Data_write(Data_write),
        .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3), .Stall(Stall),
        .Data_read(Data_read), .Read_valid(Read_valid), .Addr_err(Addr_err)
    );

    data_memory_sized #(.DEPTH_BYTES(1024), .ADDR_WIDTH(64), .MISALIGN_EN(1'b0)) dut_nomis (
        .Clk(Clk), .Reset_n(Reset_n), .address(address), .Data_write(Data_write),
        .MemWrite(MemWrite), .MemRead(MemRead), .funct3(funct3), .Stall(Stall0),
        .Data_read(Data_read0), .Read_valid(Read_valid0), .Addr_err(Addr_err0)
    );

    typedef struct {
        string       name;
        logic        rd;
        logic        wr;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        exp_vld;
        logic        exp_err;
        logic        chk_dat;
        logic [63:0] exp_dat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%h, expected 0x%h", name, act, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [2:0] f3,
                         input logic [63:0] a, input logic [63:0] wd);
        MemRead    = rd;
        MemWrite   = wr;
        funct3     = f3;
        address    = a;
        Data_write = wd;
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic load_chk(input string name, input logic [2:0] f3, input logic [63:0] a,
                            input logic [63:0] exp);
        drive(1'b1, 1'b0, f3, a, 64'h0);
        #1 check({name, " stall"}, 64'(Stall), 64'h0);
        tick();
        check({name, " vld"}, 64'(Read_valid), 64'h1);
        check({name, " err"}, 64'(Addr_err), 64'h0);
        check({name, " data"}, Data_read, exp);
        drive(1'b0, 1'b0, F_D, 64'h0, 64'h0);
    endtask

    task automatic split_load(input string name, input logic [2:0] f3, input logic [63:0] a,
                              input logic [63:0] exp);
        drive(1'b1, 1'b0, f3, a, 64'h0);
        #1 check({name, " stall T"}, 64'(Stall), 64'h1);
        tick();
        check({name, " stall T+1"}, 64'(Stall), 64'h0);
        check({name, " vld T+1"}, 64'(Read_valid), 64'h0);
        tick();
        check({name, " vld T+2"}, 64'(Read_valid), 64'h1);
        check({name, " err T+2"}, 64'(Addr_err), 64'h0);
        check({name, " data T+2"}, Data_read, exp);
        drive(1'b0, 1'b0, F_D, 64'h0, 64'h0);
    endtask

    initial begin
        vecs.push_back('{"sd_10",    1'b0, 1'b1, F_D,  64'h10,  64'h1122334455667788, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"ld_10",    1'b1, 1'b0, F_D,  64'h10,  64'h0, 1'b1, 1'b0, 1'b1, 64'h1122334455667788});
        vecs.push_back('{"sb_20",    1'b0, 1'b1, F_B,  64'h20,  64'hDEADBEEFCAFE1280, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"lb_20",    1'b1, 1'b0, F_B,  64'h20,  64'h0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFF80});
        vecs.push_back('{"lbu_20",   1'b1, 1'b0, F_BU, 64'h20,  64'h0, 1'b1, 1'b0, 1'b1, 64'h80});
        vecs.push_back('{"sh_22",    1'b0, 1'b1, F_H,  64'h22,  64'h00000000FFFF8001, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"lh_22",    1'b1, 1'b0, F_H,  64'h22,  64'h0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFF8001});
        vecs.push_back('{"lhu_22",   1'b1, 1'b0, F_HU, 64'h22,  64'h0, 1'b1, 1'b0, 1'b1, 64'h8001});
        vecs.push_back('{"sw_24",    1'b0, 1'b1, F_W,  64'h24,  64'hFFFFFFFF80000000, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"lwu_24",   1'b1, 1'b0, F_WU, 64'h24,  64'h0, 1'b1, 1'b0, 1'b1, 64'h0000000080000000});
        vecs.push_back('{"lw_24",    1'b1, 1'b0, F_W,  64'h24,  64'h0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFF80000000});
        vecs.push_back('{"ld_20",    1'b1, 1'b0, F_D,  64'h20,  64'h0, 1'b1, 1'b0, 1'b1, 64'h8000000080010080});
        vecs.push_back('{"sw_3fc",   1'b0, 1'b1, F_W,  64'h3FC, 64'h00000000CAFEF00D, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"ld_3fc_e", 1'b1, 1'b0, F_D,  64'h3FC, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"sd_3fc_e", 1'b0, 1'b1, F_D,  64'h3FC, 64'hFFFFFFFFFFFFFFFF, 1'b0, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"lwu_3fc",  1'b1, 1'b0, F_WU, 64'h3FC, 64'h0, 1'b1, 1'b0, 1'b1, 64'hCAFEF00D});
        vecs.push_back('{"lb_3ff",   1'b1, 1'b0, F_B,  64'h3FF, 64'h0, 1'b1, 1'b0, 1'b1, 64'hFFFFFFFFFFFFFFCA});
        vecs.push_back('{"lh_3ff_e", 1'b1, 1'b0, F_H,  64'h3FF, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"ld_3f8",   1'b1, 1'b0, F_D,  64'h3F8, 64'h0, 1'b1, 1'b0, 1'b1, 64'hCAFEF00D00000000});
        vecs.push_back('{"ld_hi_e",  1'b1, 1'b0, F_D,  64'h100000010, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"l111_e",   1'b1, 1'b0, F_BAD, 64'h30, 64'h0, 1'b1, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"s111_e",   1'b0, 1'b1, F_BAD, 64'h30, 64'h55, 1'b0, 1'b1, 1'b1, 64'h0});
        vecs.push_back('{"sw_rw_40", 1'b1, 1'b1, F_W,  64'h40,  64'h12345678, 1'b0, 1'b0, 1'b0, 64'h0});
        vecs.push_back('{"lw_40",    1'b1, 1'b0, F_W,  64'h40,  64'h0, 1'b1, 1'b0, 1'b1, 64'h12345678});
        vecs.push_back('{"sb_0c",    1'b0, 1'b1, F_B,  64'h0C,  64'h5A, 1'b0, 1'b0, 1'b0, 64'h0});

        // Reset with a crossing load pending: everything stays quiet.
        Reset_n = 1'b0;
        drive(1'b1, 1'b0, F_D, 64'h0D, 64'h0);
        for (int c = 0; c < 3; c++) begin
            tick();
            check("rst stall", 64'(Stall), 64'h0);
            check("rst vld", 64'(Read_valid), 64'h0);
            check("rst err", 64'(Addr_err), 64'h0);
            check("rst data", Data_read, 64'h0);
        end
        Reset_n = 1'b1;
        drive(1'b0, 1'b0, F_D, 64'h0, 64'h0);

        foreach (vecs[n]) begin
            drive(vecs[n].rd, vecs[n].wr, vecs[n].f3, vecs[n].addr, vecs[n].wd);
            #1 check({vecs[n].name, " stall"}, 64'(Stall), 64'h0);
            tick();
            check({vecs[n].name, " vld"}, 64'(Read_valid), 64'(vecs[n].exp_vld));
            check({vecs[n].name, " err"}, 64'(Addr_err), 64'(vecs[n].exp_err));
            if (vecs[n].chk_dat) begin
                check({vecs[n].name, " data"}, Data_read, vecs[n].exp_dat);
            end
        end

        // Crossing store then crossing load at 0x0D.
        drive(1'b0, 1'b1, F_D, 64'h0D, 64'hAABBCCDDEEFF0011);
        #1 check("sd_0d stall T", 64'(Stall), 64'h1);
        tick();
        check("sd_0d stall T+1", 64'(Stall), 64'h0);
        tick();
        check("sd_0d err", 64'(Addr_err), 64'h0);
        split_load("ld_0d", F_D, 64'h0D, 64'hAABBCCDDEEFF0011);
        tick();
        check("ld_0d vld pulse end", 64'(Read_valid), 64'h0);
        check("ld_0d data hold", Data_read, 64'hAABBCCDDEEFF0011);
        load_chk("lbu_0c", F_BU, 64'h0C, 64'h5A);
        load_chk("lbu_15", F_BU, 64'h15, 64'h33);
        load_chk("ld_10b", F_D, 64'h10, 64'h112233AABBCCDDEE);
        split_load("lh_0f", F_H, 64'h0F, 64'hFFFFFFFFFFFFEEFF);

        // Reset lands in the SPLIT cycle of a crossing store at 0x0E.
        drive(1'b0, 1'b1, F_D, 64'h0E, 64'h0102030405060708);
        #1 check("sd_0e stall T", 64'(Stall), 64'h1);
        tick();
        Reset_n = 1'b0;
        #1 check("sd_0e stall in rst", 64'(Stall), 64'h0);
        tick();
        check("sd_0e rst vld", 64'(Read_valid), 64'h0);
        check("sd_0e rst data", Data_read, 64'h0);
        Reset_n = 1'b1;
        drive(1'b0, 1'b0, F_D, 64'h0, 64'h0);
        tick();
        load_chk("ld_10c", F_D, 64'h10, 64'h112233AABBCCDDEE);
        load_chk("lhu_0e", F_HU, 64'h0E, 64'h0708);
        load_chk("lbu_0d", F_BU, 64'h0D, 64'h11);

        // Boundary-crossing word load: error without misalign support, split with it.
        drive(1'b1, 1'b0, F_W, 64'h06, 64'h0);
        #1 check("nomis stall", 64'(Stall0), 64'h0);
        check("mis stall", 64'(Stall), 64'h1);
        tick();
        check("nomis err", 64'(Addr_err0), 64'h1);
        check("nomis vld", 64'(Read_valid0), 64'h1);
        check("nomis data", Data_read0, 64'h0);
        tick();
        check("mis lw_06 vld", 64'(Read_valid), 64'h1);
        check("mis lw_06 data", Data_read, 64'h0);
        check("mis lw_06 err", 64'(Addr_err), 64'h0);
        drive(1'b0, 1'b0, F_D, 64'h0, 64'h0);
        tick();
        check("nomis err end", 64'(Addr_err0), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
